// File: rtl/neuron_pkg.sv
// Shared state encoding, descriptor layout and default widths for the
// neuron layer sequencer and its helpers.
package neuron_pkg;

    localparam int unsigned NEURON_DWIDTH = 32;
    localparam int unsigned NEURON_AWIDTH = 12;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RUN,
        DRAIN,
        WRITE,
        FINISH
    } state_t;

    typedef struct packed {
        logic [NEURON_AWIDTH-1:0] in_base;
        logic [NEURON_AWIDTH-1:0] w_base;
        logic [NEURON_AWIDTH-1:0] out_base;
        logic [NEURON_AWIDTH-1:0] idim;
        logic [NEURON_AWIDTH-1:0] odim;
    } desc_t;

endpackage

// File: rtl/neuron_seq_done_latch.sv
// Pair of sticky stream-completion latches; o_both rises once both
// streams have reported done since the last clear, in any order.
module neuron_seq_done_latch (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_arm,
    input  logic i_done_a,
    input  logic i_done_b,
    output logic o_both
);

    logic r_a;
    logic r_b;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a <= 1'b0;
            r_b <= 1'b0;
        end else if (i_clr) begin
            r_a <= 1'b0;
            r_b <= 1'b0;
        end else if (i_arm) begin
            if (i_done_a) r_a <= 1'b1;
            if (i_done_b) r_b <= 1'b1;
        end
    end

    assign o_both = r_a & r_b;

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Sequences one fully connected layer over the Streamer/NeuronCore datapath.
// Optional NEURON_SEQ_PERF_EN adds busy-cycle and neuron-write counters.
module neuron_layer_sequencer
    import neuron_pkg::*;
#(
    parameter int unsigned DWIDTH       = NEURON_DWIDTH,
    parameter int unsigned AWIDTH       = NEURON_AWIDTH,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [AWIDTH-1:0] i_cmd_in_base,
    input  logic [AWIDTH-1:0] i_cmd_w_base,
    input  logic [AWIDTH-1:0] i_cmd_out_base,
    input  logic [AWIDTH-1:0] i_cmd_idim,
    input  logic [AWIDTH-1:0] i_cmd_odim,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_stream_a_en,
    output logic              o_stream_b_en,
    output logic [DWIDTH-1:0] o_stream_a_start,
    output logic [DWIDTH-1:0] o_stream_a_limit,
    output logic [DWIDTH-1:0] o_stream_b_start,
    output logic [DWIDTH-1:0] o_stream_b_limit,
    input  logic              i_stream_a_done,
    input  logic              i_stream_b_done,
    output logic              o_neuron_start,
    input  logic [DWIDTH-1:0] i_neuron_result,
    output logic              o_wb_we,
    output logic [AWIDTH-1:0] o_wb_addr,
    output logic [DWIDTH-1:0] o_wb_data
`ifdef NEURON_SEQ_PERF_EN
    ,
    output logic [31:0]       o_perf_cycles,
    output logic [AWIDTH-1:0] o_perf_neurons
`endif
);

    localparam int unsigned DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t            r_state;
    logic [AWIDTH-1:0] r_out_base;
    logic [AWIDTH-1:0] r_idim;
    logic [AWIDTH-1:0] r_odim;
    logic [AWIDTH-1:0] r_wptr;
    logic [AWIDTH-1:0] r_j;
    logic [DCW-1:0]    r_drain;
    logic              r_busy;
    logic              r_done;
    logic              r_en;
    logic              r_start;
    logic              r_we;
    logic [AWIDTH-1:0] r_wb_addr;
    logic [DWIDTH-1:0] r_wb_data;
    logic [DWIDTH-1:0] r_a_start;
    logic [DWIDTH-1:0] r_a_limit;
    logic [DWIDTH-1:0] r_b_start;
    logic [DWIDTH-1:0] r_b_limit;

    logic              w_both;
    logic              w_accept;
    logic [AWIDTH-1:0] w_cmd_a_limit;
    logic [AWIDTH-1:0] w_cmd_b_limit;
    logic [AWIDTH-1:0] w_wptr_next;
    logic [AWIDTH-1:0] w_b_limit_next;

    assign w_accept       = (r_state == IDLE) && i_cmd_valid;
    assign w_cmd_a_limit  = i_cmd_in_base + i_cmd_idim;
    assign w_cmd_b_limit  = i_cmd_w_base + i_cmd_idim;
    assign w_wptr_next    = r_wptr + r_idim;
    assign w_b_limit_next = w_wptr_next + r_idim;

    neuron_seq_done_latch u_done_latch (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (r_state == SETUP),
        .i_arm    (r_state == RUN),
        .i_done_a (i_stream_a_done),
        .i_done_b (i_stream_b_done),
        .o_both   (w_both)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_out_base <= '0;
            r_idim     <= '0;
            r_odim     <= '0;
            r_wptr     <= '0;
            r_j        <= '0;
            r_drain    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_en       <= 1'b0;
            r_start    <= 1'b0;
            r_we       <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_a_start  <= '0;
            r_a_limit  <= '0;
            r_b_start  <= '0;
            r_b_limit  <= '0;
        end else begin
            r_done <= 1'b0;
            r_we   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        r_out_base <= i_cmd_out_base;
                        r_idim     <= i_cmd_idim;
                        r_odim     <= i_cmd_odim;
                        r_wptr     <= i_cmd_w_base;
                        r_j        <= '0;
                        r_busy     <= 1'b1;
                        // Ranges are loaded here so they are already valid during SETUP.
                        r_a_start  <= DWIDTH'(i_cmd_in_base);
                        r_a_limit  <= DWIDTH'(w_cmd_a_limit);
                        r_b_start  <= DWIDTH'(i_cmd_w_base);
                        r_b_limit  <= DWIDTH'(w_cmd_b_limit);
                        if (i_cmd_idim == '0 || i_cmd_odim == '0) begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    r_state <= RUN;
                    r_en    <= 1'b1;
                    r_start <= 1'b1;
                end
                RUN: begin
                    if (w_both) begin
                        r_state <= DRAIN;
                        r_en    <= 1'b0;
                        r_start <= 1'b0;
                        r_drain <= DCW'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (r_drain == '0) begin
                        r_state   <= WRITE;
                        r_we      <= 1'b1;
                        r_wb_addr <= r_out_base + r_j;
                        r_wb_data <= i_neuron_result;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                WRITE: begin
                    r_j       <= r_j + 1'b1;
                    r_wptr    <= w_wptr_next;
                    r_b_start <= DWIDTH'(w_wptr_next);
                    r_b_limit <= DWIDTH'(w_b_limit_next);
                    if (r_j == r_odim - 1'b1) begin
                        r_state <= FINISH;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= SETUP;
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef NEURON_SEQ_PERF_EN
    logic [31:0]       r_perf_cycles;
    logic [AWIDTH-1:0] r_perf_neurons;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf_cycles  <= '0;
            r_perf_neurons <= '0;
        end else if (w_accept) begin
            r_perf_cycles  <= '0;
            r_perf_neurons <= '0;
        end else begin
            if (r_busy && r_perf_cycles != '1) r_perf_cycles <= r_perf_cycles + 32'd1;
            if (r_state == WRITE) r_perf_neurons <= r_perf_neurons + 1'b1;
        end
    end

    assign o_perf_cycles  = r_perf_cycles;
    assign o_perf_neurons = r_perf_neurons;
`endif

    assign o_cmd_ready      = (r_state == IDLE);
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_stream_a_en    = r_en;
    assign o_stream_b_en    = r_en;
    assign o_neuron_start   = r_start;
    assign o_stream_a_start = r_a_start;
    assign o_stream_a_limit = r_a_limit;
    assign o_stream_b_start = r_b_start;
    assign o_stream_b_limit = r_b_limit;
    assign o_wb_we          = r_we;
    assign o_wb_addr        = r_wb_addr;
    assign o_wb_data        = r_wb_data;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Scoreboarded bench for neuron_layer_sequencer; define NEURON_SEQ_PERF_EN
// to also cover the performance counters.
module tb_neuron_layer_sequencer;
    import neuron_pkg::*;

    localparam int D = 4;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wexp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd_in_base = '0, cmd_w_base = '0, cmd_out_base = '0, cmd_idim = '0, cmd_odim = '0;
    logic        busy, done, a_en, b_en, neuron_start, wb_we;
    logic [31:0] a_start, a_limit, b_start, b_limit;
    logic        a_done = 1'b0, b_done = 1'b0;
    logic [31:0] neuron_result = '0;
    logic [11:0] wb_addr;
    logic [31:0] wb_data;
`ifdef NEURON_SEQ_PERF_EN
    logic [31:0] perf_cycles;
    logic [11:0] perf_neurons;
`endif

    int errors = 0;
    int checks = 0;
    int dly_a = 10, dly_b = 10;
    int a_cnt = 0, b_cnt = 0;
    logic prev_en = 1'b0;
    wexp_t        wq[$];
    logic [127:0] rq[$];

    neuron_layer_sequencer #(.DWIDTH(32), .AWIDTH(12), .DRAIN_CYCLES(D)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_in_base(cmd_in_base), .i_cmd_w_base(cmd_w_base), .i_cmd_out_base(cmd_out_base),
        .i_cmd_idim(cmd_idim), .i_cmd_odim(cmd_odim), .o_busy(busy), .o_done(done),
        .o_stream_a_en(a_en), .o_stream_b_en(b_en),
        .o_stream_a_start(a_start), .o_stream_a_limit(a_limit),
        .o_stream_b_start(b_start), .o_stream_b_limit(b_limit),
        .i_stream_a_done(a_done), .i_stream_b_done(b_done), .o_neuron_start(neuron_start),
        .i_neuron_result(neuron_result), .o_wb_we(wb_we), .o_wb_addr(wb_addr), .o_wb_data(wb_data)
`ifdef NEURON_SEQ_PERF_EN
        , .o_perf_cycles(perf_cycles), .o_perf_neurons(perf_neurons)
`endif
    );

    always #5 clk = ~clk;

    // Streamer/NeuronCore stand-in: each stream reports done dly_x cycles into its run.
    initial begin
        forever begin
            @(negedge clk);
            if (a_en) a_cnt++; else a_cnt = 0;
            if (b_en) b_cnt++; else b_cnt = 0;
            a_done = a_en && (a_cnt == dly_a);
            b_done = b_en && (b_cnt == dly_b);
            if (b_en) neuron_result = 32'h5A00_0000 ^ b_start;
        end
    end

    // Scoreboard consumer: writes and per-neuron stream ranges.
    initial begin
        wexp_t        we_exp;
        logic [127:0] r_exp;
        forever begin
            @(negedge clk);
            if (rst_n && wb_we) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected: addr=%0d data=%h, required no write", wb_addr, wb_data);
                end else begin
                    we_exp = wq.pop_front();
                    if ({wb_addr, wb_data} !== {we_exp.addr, we_exp.data}) begin
                        errors++;
                        $display("FAIL wb_write: addr=%0d data=%h, required addr=%0d data=%h",
                                 wb_addr, wb_data, we_exp.addr, we_exp.data);
                    end
                end
            end
            if (rst_n && a_en && !prev_en) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL range_unexpected: stream run started with no pending neuron");
                end else begin
                    r_exp = rq.pop_front();
                    if ({a_start, a_limit, b_start, b_limit} !== r_exp) begin
                        errors++;
                        $display("FAIL ranges: got %h, required %h",
                                 {a_start, a_limit, b_start, b_limit}, r_exp);
                    end
                end
            end
            prev_en = a_en;
        end
    end

    task automatic issue_cmd(input desc_t d, input int dla, input int dlb, input bit hold_garbage);
        logic [11:0] bs;
        @(negedge clk);
        dly_a = dla;
        dly_b = dlb;
        {cmd_in_base, cmd_w_base, cmd_out_base, cmd_idim, cmd_odim} = d;
        cmd_valid = 1'b1;
        if (d.idim != 0 && d.odim != 0) begin
            bs = d.w_base;
            for (int j = 0; j < int'(d.odim); j++) begin
                wq.push_back('{addr: d.out_base + 12'(j), data: 32'h5A00_0000 ^ {20'd0, bs}});
                rq.push_back({20'd0, d.in_base, 20'd0, 12'(d.in_base + d.idim),
                              20'd0, bs, 20'd0, 12'(bs + d.idim)});
                bs = bs + d.idim;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = hold_garbage;
        {cmd_in_base, cmd_w_base, cmd_out_base, cmd_idim, cmd_odim} = {$urandom, $urandom};
    endtask

    task automatic wait_done(input int budget, output int busy_len, output int nwr, output int start_hi,
                             output bit busy_gap, output int done_after_wr, output bit timeout);
        int last_wr;
        busy_len = 0; nwr = 0; start_hi = 0; busy_gap = 0; done_after_wr = -1; timeout = 1;
        last_wr = -100;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (k == 6) cmd_valid = 1'b0;
            if (busy) busy_len++; else busy_gap = 1;
            if (neuron_start) start_hi++;
            if (wb_we) begin nwr++; last_wr = k; end
            if (done) begin done_after_wr = k - last_wr; timeout = 0; break; end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_en, b_en, neuron_start, busy, done, wb_we, cmd_ready} !== 7'b0000001) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 0000001",
                     {a_en, b_en, neuron_start, busy, done, wb_we, cmd_ready});
        end
        checks++;
        if ({a_start, a_limit, b_start, b_limit, wb_addr, wb_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: outputs not all zero");
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        int bl, nw, sh, dw; bit gap, to;
        issue_cmd('{in_base: 10, w_base: 20, out_base: 100, idim: 10, odim: 1}, 10, 10, 1'b0);
        wait_done(200, bl, nw, sh, gap, dw, to);
        checks++;
        if (to || nw != 1) begin errors++; $display("FAIL single_writes: writes=%0d timeout=%0d, required 1 write", nw, to); end
        checks++;
        if (dw != 1) begin errors++; $display("FAIL single_done_lag: done %0d cycles after write, required 1", dw); end
        checks++;
        if (bl != 1 * (2 + 11 + D) + 1) begin errors++; $display("FAIL single_busy_len: got %0d, required %0d", bl, 2 + 11 + D + 1); end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: ready=%b busy=%b, required 1 0", cmd_ready, busy); end
    endtask

    task automatic test_multi;
        int bl, nw, sh, dw; bit gap, to;
        issue_cmd('{in_base: 10, w_base: 20, out_base: 100, idim: 10, odim: 3}, 10, 10, 1'b1);
        wait_done(300, bl, nw, sh, gap, dw, to);
        checks++;
        if (to || nw != 3) begin errors++; $display("FAIL multi_writes: writes=%0d timeout=%0d, required 3", nw, to); end
        checks++;
        if (gap) begin errors++; $display("FAIL multi_busy_gap: busy dropped mid-layer, required continuous"); end
        checks++;
        if (bl != 3 * (2 + 11 + D) + 1) begin errors++; $display("FAIL multi_busy_len: got %0d, required %0d", bl, 3 * (2 + 11 + D) + 1); end
    endtask

    task automatic test_skew;
        int bl, nw, sh, dw; bit gap, to;
        issue_cmd('{in_base: 0, w_base: 200, out_base: 300, idim: 5, odim: 1}, 5, 8, 1'b0);
        wait_done(200, bl, nw, sh, gap, dw, to);
        checks++;
        if (to || sh != 9) begin errors++; $display("FAIL skew_start_len: neuron_start high %0d cycles, required 9", sh); end
        checks++;
        if (bl != 2 + 9 + D + 1) begin errors++; $display("FAIL skew_busy_len: got %0d, required %0d", bl, 2 + 9 + D + 1); end
    endtask

    task automatic test_zero_dim;
        for (int z = 0; z < 2; z++) begin
            if (z == 0) issue_cmd('{in_base: 1, w_base: 2, out_base: 3, idim: 7, odim: 0}, 10, 10, 1'b0);
            else        issue_cmd('{in_base: 1, w_base: 2, out_base: 3, idim: 0, odim: 7}, 10, 10, 1'b0);
            @(negedge clk);
            checks++;
            if ({done, busy, cmd_ready, wb_we} !== 4'b1100) begin
                errors++;
                $display("FAIL zero_done[%0d]: done/busy/ready/we=%b, required 1100", z, {done, busy, cmd_ready, wb_we});
            end
            @(negedge clk);
            checks++;
            if ({done, busy, cmd_ready, wb_we} !== 4'b0010) begin
                errors++;
                $display("FAIL zero_idle[%0d]: done/busy/ready/we=%b, required 0010", z, {done, busy, cmd_ready, wb_we});
            end
        end
    endtask

    task automatic test_reset_mid_run;
        int rises, bl, nw, sh, dw; bit gap, to, prev, found;
        issue_cmd('{in_base: 10, w_base: 20, out_base: 100, idim: 10, odim: 3}, 10, 10, 1'b0);
        rises = 0; prev = 0; found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (neuron_start && !prev) rises++;
            prev = neuron_start;
            if (rises == 2) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rst_reach_run: second neuron never started, required start"); end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_en, b_en, neuron_start, busy, wb_we, cmd_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL rst_async: en_a/en_b/start/busy/we/ready=%b, required 000001",
                     {a_en, b_en, neuron_start, busy, wb_we, cmd_ready});
        end
        nw = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (wb_we) nw++;
        end
        checks++;
        if (nw != 0) begin errors++; $display("FAIL rst_no_write: %0d writes under reset, required 0", nw); end
        wq.delete();
        rq.delete();
        rst_n = 1'b1;
        issue_cmd('{in_base: 10, w_base: 20, out_base: 100, idim: 10, odim: 2}, 10, 10, 1'b0);
        wait_done(300, bl, nw, sh, gap, dw, to);
        checks++;
        if (to || nw != 2) begin errors++; $display("FAIL rst_rerun: writes=%0d timeout=%0d, required 2", nw, to); end
    endtask

    task automatic test_wrap;
        int bl, nw, sh, dw; bit gap, to;
        issue_cmd('{in_base: 4090, w_base: 4090, out_base: 4095, idim: 10, odim: 2}, 3, 4, 1'b0);
        wait_done(200, bl, nw, sh, gap, dw, to);
        checks++;
        if (to || nw != 2) begin errors++; $display("FAIL wrap_writes: writes=%0d timeout=%0d, required 2", nw, to); end
    endtask

    task automatic test_perf;
        int bl, nw, sh, dw; bit gap, to;
        issue_cmd('{in_base: 10, w_base: 20, out_base: 100, idim: 10, odim: 2}, 10, 10, 1'b0);
        wait_done(300, bl, nw, sh, gap, dw, to);
        checks++;
        if (to || bl != 2 * (2 + 11 + D) + 1) begin errors++; $display("FAIL perf_busy_len: got %0d, required %0d", bl, 2 * (2 + 11 + D) + 1); end
`ifdef NEURON_SEQ_PERF_EN
        repeat (2) @(negedge clk);
        checks++;
        if (perf_cycles !== 32'(bl)) begin errors++; $display("FAIL perf_cycles: got %0d, required %0d", perf_cycles, bl); end
        checks++;
        if (perf_neurons !== 12'd2) begin errors++; $display("FAIL perf_neurons: got %0d, required 2", perf_neurons); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_skew();
        test_zero_dim();
        test_reset_mid_run();
        test_wrap();
        test_perf();
        repeat (5) @(negedge clk);
        checks++;
        if (wq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d writes and %0d ranges outstanding, required 0", wq.size(), rq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
